conv_mac: RTL and testbench

CONV_MAC -- requirements
Module: conv_mac

---
 rtl/conv_mac_pkg.sv | 16 +
 rtl/conv_mac_mult.sv | 28 ++
 rtl/conv_mac.sv | 100 ++++++++++
 tb/tb_conv_mac.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_mac_pkg.sv
// Shared types and sizing for the convolution MAC slice (package Conv).
// Optional build macro: CONV_SIGNED_EN selects two's-complement operands.
package Conv;

  localparam int WIDTH        = 8;
  localparam int LEN          = 4;
  // Wide enough for LEN full-scale products, so the sum can never wrap.
  localparam int RESULT_WIDTH = 2 * WIDTH + $clog2(LEN);
  // Tap index width, kept at least 1 bit for the degenerate LEN == 1 case.
  localparam int IDX_W        = (LEN > 1) ? $clog2(LEN) : 1;

  typedef logic [WIDTH-1:0]        data_t;
  typedef data_t [LEN-1:0]         data_vector;
  typedef logic [RESULT_WIDTH-1:0] result_t;

endpackage

// File: rtl/conv_mac_mult.sv
// Combinational WIDTH x WIDTH multiplier producing a RESULT_WIDTH product.
// Build macro CONV_SIGNED_EN: operands are sign-extended; otherwise zero-extended.
import Conv::*;

module conv_mult (
  input  data_t   a,
  input  data_t   b,
  output result_t p
);

`ifdef CONV_SIGNED_EN
  logic signed [RESULT_WIDTH-1:0] a_ext;
  logic signed [RESULT_WIDTH-1:0] b_ext;

  // Sign-extend both operands to full width, then multiply at that width.
  always_comb begin
    a_ext = RESULT_WIDTH'(signed'(a));
    b_ext = RESULT_WIDTH'(signed'(b));
    p     = result_t'(a_ext * b_ext);
  end
`else
  // Zero-extend both operands to full width, then multiply at that width.
  always_comb begin
    p = result_t'(a) * result_t'(b);
  end
`endif

endmodule

// File: rtl/conv_mac.sv
// Serial dot-product engine: latches LEN samples and LEN coefficients,
// accumulates one product per cycle through a single multiplier, then holds
// the result until downstream takes it.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, holds with its payload until that edge, and
// ready never depends combinationally on valid.
// Build macro CONV_SIGNED_EN: treat operands as two's-complement signed.
import Conv::*;

module conv_mac (
  input  logic       clk,
  input  logic       rst,
  input  data_vector data,
  input  logic       in_valid,
  output logic       in_ready,
  input  data_vector kernel,
  output result_t    result,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  data_vector       data_q;
  data_vector       kernel_q;
  result_t          acc;
  result_t          acc_next;
  result_t          prod;
  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             last_tap;

  assign accept    = in_valid && in_ready && (state == IDLE);
  assign last_tap  = (idx == IDX_W'(LEN - 1));
  assign acc_next  = acc + prod;
  assign state_dbg = state;

  conv_mult u_mult (
    .a (data_q[idx]),
    .b (kernel_q[idx]),
    .p (prod)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: accept, run LEN taps, then wait for the result handoff.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CALC;
      CALC:    if (last_tap) state_next = DONE;
      DONE:    if (out_valid && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered handshake flags, all keyed off the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      acc       <= '0;
      idx       <= '0;
      data_q    <= '0;
      kernel_q  <= '0;
    end else begin
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            data_q   <= data;
            kernel_q <= kernel;
            acc      <= '0;
            idx      <= '0;
          end
        end
        CALC: begin
          acc <= acc_next;
          if (last_tap) result <= acc_next;
          else          idx    <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mac.sv
// Directed bench for conv_mac (LEN=4, WIDTH=8); signed vectors run when
// CONV_SIGNED_EN is defined, unsigned full-scale vectors otherwise.
import Conv::*;

module tb_conv_mac;

  logic       clk;
  logic       rst;
  data_vector data;
  logic       in_valid;
  logic       in_ready;
  data_vector kernel;
  result_t    result;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] state_dbg;

  int tests_run    = 0;
  int tests_failed = 0;

  conv_mac dut (
    .clk       (clk),
    .rst       (rst),
    .data      (data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .kernel    (kernel),
    .result    (result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_dbg (state_dbg)
  );

  // Clock: 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one transaction at a negedge with in_ready high; returns at the
  // negedge following the acceptance edge.
  task automatic start_txn(input data_vector d, input data_vector k);
    data     = d;
    kernel   = k;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count edges from the acceptance edge (inclusive) until out_valid is seen.
  task automatic wait_valid(output int edges);
    edges = 1;
    while (!out_valid && edges < 40) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data      = '0;
    kernel    = '0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || state_dbg !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset: in_ready=%b out_valid=%b result=%0d state=%0d, want 1 0 0 0",
               in_ready, out_valid, result, state_dbg);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ones();
    int edges;
    out_ready = 1'b1;
    start_txn({LEN{8'd1}}, {LEN{8'd2}});
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL ones_busy: in_ready=%b want 0", in_ready);
    end
    wait_valid(edges);
    tests_run++;
    if (edges != LEN + 1 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL ones_latency: edges=%0d out_valid=%b want %0d 1", edges, out_valid, LEN + 1);
    end
    tests_run++;
    if (result !== result_t'(2 * LEN)) begin
      tests_failed++;
      $display("FAIL ones_result: got %0d want %0d", result, 2 * LEN);
    end
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== result_t'(2 * LEN)) begin
      tests_failed++;
      $display("FAIL ones_handoff: in_ready=%b out_valid=%b result=%0d want 1 0 %0d",
               in_ready, out_valid, result, 2 * LEN);
    end
  endtask

  task automatic test_mixed();
    int edges;
    out_ready = 1'b1;
    start_txn({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5});
    wait_valid(edges);
    tests_run++;
    if (out_valid !== 1'b1 || result !== result_t'(70)) begin
      tests_failed++;
      $display("FAIL mixed: out_valid=%b result=%0d want 1 70", out_valid, result);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

`ifdef CONV_SIGNED_EN
  task automatic test_signed();
    int edges;
    result_t exp_val;
    exp_val   = '0 - result_t'(LEN);
    out_ready = 1'b1;
    start_txn({LEN{8'hFF}}, {LEN{8'h01}});
    wait_valid(edges);
    tests_run++;
    if (out_valid !== 1'b1 || result !== exp_val) begin
      tests_failed++;
      $display("FAIL signed_neg: out_valid=%b result=%h want 1 %h", out_valid, result, exp_val);
    end
    @(posedge clk);
    @(negedge clk);
  endtask
`else
  task automatic test_max();
    int edges;
    out_ready = 1'b1;
    start_txn({LEN{8'hFF}}, {LEN{8'hFF}});
    wait_valid(edges);
    tests_run++;
    if (out_valid !== 1'b1 || result !== result_t'(LEN * 65025)) begin
      tests_failed++;
      $display("FAIL unsigned_max: out_valid=%b result=%0d want 1 %0d", out_valid, result, LEN * 65025);
    end
    @(posedge clk);
    @(negedge clk);
  endtask
`endif

  task automatic test_kernel_change();
    int edges;
    out_ready = 1'b1;
    start_txn({8'd4, 8'd3, 8'd2, 8'd1}, {LEN{8'd1}});
    data   = {LEN{8'hFF}};
    kernel = {LEN{8'd9}};
    wait_valid(edges);
    tests_run++;
    if (out_valid !== 1'b1 || result !== result_t'(10)) begin
      tests_failed++;
      $display("FAIL kernel_change: out_valid=%b result=%0d want 1 10", out_valid, result);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int edges;
    out_ready = 1'b0;
    start_txn({8'd1, 8'd2, 8'd3, 8'd4}, {8'd1, 8'd1, 8'd1, 8'd2});
    wait_valid(edges);
    in_valid = 1'b1;
    data     = {LEN{8'd7}};
    kernel   = {LEN{8'd7}};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b1 || result !== result_t'(14) || in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL backpressure_hold[%0d]: out_valid=%b result=%0d in_ready=%b want 1 14 0",
                 i, out_valid, result, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || state_dbg !== 2'd0) begin
      tests_failed++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b state=%0d want 1 0 0",
               in_ready, out_valid, state_dbg);
    end
  endtask

  task automatic test_reset_mid();
    int edges;
    out_ready = 1'b1;
    start_txn({LEN{8'd3}}, {LEN{8'd3}});
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid: out_valid=%b in_ready=%b result=%0d want 0 1 0",
               out_valid, in_ready, result);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_txn({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5});
    wait_valid(edges);
    tests_run++;
    if (out_valid !== 1'b1 || result !== result_t'(70) || edges != LEN + 1) begin
      tests_failed++;
      $display("FAIL reset_recover: out_valid=%b result=%0d edges=%0d want 1 70 %0d",
               out_valid, result, edges, LEN + 1);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int edges;
    out_ready = 1'b1;
    start_txn({LEN{8'd2}}, {LEN{8'd3}});
    wait_valid(edges);
    tests_run++;
    if (result !== result_t'(6 * LEN)) begin
      tests_failed++;
      $display("FAIL b2b_first: result=%0d want %0d", result, 6 * LEN);
    end
    @(posedge clk);
    @(negedge clk);
    start_txn({8'd0, 8'd10, 8'd0, 8'd5}, {8'd9, 8'd2, 8'd9, 8'd4});
    wait_valid(edges);
    tests_run++;
    if (result !== result_t'(40) || edges != LEN + 1) begin
      tests_failed++;
      $display("FAIL b2b_second: result=%0d edges=%0d want 40 %0d", result, edges, LEN + 1);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_ones();
    test_mixed();
`ifdef CONV_SIGNED_EN
    test_signed();
`else
    test_max();
`endif
    test_kernel_change();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
